// File: rtl/axis2serial_pkg.sv
// rtl/axis2serial_pkg.sv - shared types and constants for the AXIS-to-serial transmitter
//
// Purpose : state encoding, default widths and the bit-counter width helper
//           used by axis2serial and SerialEdgeSync.
package Axis2SerialPkg;

  localparam int DATA_WIDTH_DEF  = 32;
  localparam int SYNC_STAGES_DEF = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Bit counter wide enough to index every bit of one serial word.
  function automatic int cnt_width(input int dw);
    return (dw > 1) ? $clog2(dw) : 1;
  endfunction

endpackage

// File: rtl/axis2serial_edge_sync.sv
// rtl/axis2serial_edge_sync.sv - synchronizer with one-cycle rise/fall strobes
//
// Purpose : brings an asynchronous pin into the i_clk domain through STAGES
//           flops, then one edge-detect flop produces single-cycle strobes.
// Ports   : i_clk, i_rst (async, active-high)
//           i_async  - asynchronous input pin
//           o_rise   - one-cycle strobe on a synchronized 0->1 transition
//           o_fall   - one-cycle strobe on a synchronized 1->0 transition
module SerialEdgeSync
  import Axis2SerialPkg::*;
#(
  parameter int   STAGES    = SYNC_STAGES_DEF,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;
  logic              w_level;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync <= {STAGES{RESET_VAL}};
      r_prev <= RESET_VAL;
    end else begin
      r_sync[0] <= i_async;
      for (int i = 1; i < STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign w_level = r_sync[STAGES-1];
  assign o_rise  = w_level & ~r_prev;
  assign o_fall  = ~w_level & r_prev;

endmodule

// File: rtl/axis2serial.sv
// rtl/axis2serial.sv - AXI-Stream word to SPI mode-0 slave MISO transmitter
//
// Purpose : buffers one AXIS word in a holding register, moves it into a shift
//           register and presents it MSB-first on serial_miso while the host
//           clocks serial_sck with serial_cs low.
// Ports   : aclk, reset (async, active-high)
//           s_axis_tvalid/tready/tlast/tdata - AXIS slave input
//           serial_sck, serial_cs (active-low) - host pins, asynchronous
//           serial_miso - serial data out; serial_rts - a word is waiting
//           frame_done  - pulse after the last bit of a tlast word
//           underrun    - sticky, host clocked an empty word; underrun_clear clears it
module axis2serial
  import Axis2SerialPkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic                  aclk,
  input  logic                  reset,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  serial_sck,
  input  logic                  serial_cs,
  output logic                  serial_miso,
  output logic                  serial_rts,
  output logic                  frame_done,
  output logic                  underrun,
  input  logic                  underrun_clear
);

  localparam int                CNT_W    = cnt_width(DATA_WIDTH);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  logic w_sck_rise, w_sck_fall;
  logic w_cs_act, w_cs_inact;

  // CS resets to its inactive (high) level so a pin already low after reset
  // still produces a cs_act strobe.
  SerialEdgeSync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sck_sync (
    .i_clk   (aclk),
    .i_rst   (reset),
    .i_async (serial_sck),
    .o_rise  (w_sck_rise),
    .o_fall  (w_sck_fall)
  );

  SerialEdgeSync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
    .i_clk   (aclk),
    .i_rst   (reset),
    .i_async (serial_cs),
    .o_rise  (w_cs_inact),
    .o_fall  (w_cs_act)
  );

  state_t                r_state, w_state_nxt;
  logic [DATA_WIDTH-1:0] r_hold, r_shreg;
  logic                  r_hold_last, r_hold_v;
  logic                  r_sh_last, r_sh_v;
  logic [CNT_W-1:0]      r_bitcnt;
  logic                  r_frame_done, r_underrun;

  logic w_shift_rise, w_shift_fall, w_abort;
  logic w_handshake, w_xfer, w_underrun_set, w_cnt_zero;

  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Leaving SHIFT takes priority over any sck strobe in the same cycle.
  always_comb begin
    w_state_nxt  = r_state;
    w_shift_rise = 1'b0;
    w_shift_fall = 1'b0;
    w_abort      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_cs_act) w_state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (w_cs_inact) begin
          w_state_nxt = ST_IDLE;
          w_abort     = 1'b1;
        end else begin
          w_shift_rise = w_sck_rise;
          w_shift_fall = w_sck_fall;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_cnt_zero     = (r_bitcnt == '0);
  assign w_handshake    = s_axis_tvalid & s_axis_tready;
  // A rising edge in the same cycle would sample before the new MSB is shown,
  // so the transfer waits one cycle for it.
  assign w_xfer         = w_cnt_zero & ~r_sh_v & r_hold_v & ~w_sck_rise;
  assign w_underrun_set = w_shift_rise & w_cnt_zero & ~r_sh_v;

  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      r_hold       <= '0;
      r_hold_last  <= 1'b0;
      r_hold_v     <= 1'b0;
      r_shreg      <= '0;
      r_sh_last    <= 1'b0;
      r_sh_v       <= 1'b0;
      r_bitcnt     <= '0;
      r_frame_done <= 1'b0;
      r_underrun   <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;

      if (w_handshake) begin
        r_hold      <= s_axis_tdata;
        r_hold_last <= s_axis_tlast;
        r_hold_v    <= 1'b1;
      end else if (w_xfer) begin
        r_hold_v    <= 1'b0;
      end

      // shreg is zeroed whenever its word is finished or dropped, so MISO
      // idles low and an underrun word shifts out zeros.
      if (w_xfer) begin
        r_shreg   <= r_hold;
        r_sh_last <= r_hold_last;
        r_sh_v    <= 1'b1;
      end else if (w_abort) begin
        if (!w_cnt_zero) begin
          r_shreg  <= '0;
          r_sh_v   <= 1'b0;
          r_bitcnt <= '0;
        end
      end else if (w_shift_rise) begin
        r_bitcnt <= r_bitcnt + 1'b1;
        if (r_bitcnt == LAST_BIT) begin
          r_shreg      <= '0;
          r_sh_v       <= 1'b0;
          r_frame_done <= r_sh_v & r_sh_last;
        end
      end else if (w_shift_fall && !w_cnt_zero) begin
        r_shreg <= {r_shreg[DATA_WIDTH-2:0], 1'b0};
      end else if (r_state == ST_IDLE) begin
        r_bitcnt <= '0;
      end

      if (w_underrun_set) begin
        r_underrun <= 1'b1;
      end else if (underrun_clear) begin
        r_underrun <= 1'b0;
      end
    end
  end

  assign s_axis_tready = ~r_hold_v & ~reset;
  assign serial_miso   = r_shreg[DATA_WIDTH-1];
  assign serial_rts    = r_sh_v | r_hold_v;
  assign frame_done    = r_frame_done;
  assign underrun      = r_underrun;

endmodule
